ceespu_mem_arbiter: RTL and testbench
=====================================

// Module: ceespu_mem_arbiter
// PURPOSE
//   Shares one single-port synchronous memory between the ceespu instruction-fetch port and data port.
//   Sits between the core's imem/dmem interfaces and the memory macro.
//   Returns fetch and load data through registered valid pulses, and stalls the losing or in-flight requester.
//   Data accesses have priority, with a streak limit so fetch is never starved.
// PARAMETERS
//   READ_LATENCY     1  memory read latency in cycles after the O_memE cycle (1..7)
//   MAX_DATA_STREAK  4  consecutive data grants allowed while a fetch is pending (1..15)
// PORTS
//   I_clk         in   1   clock; all logic on rising edge
//   I_rst         in   1   reset; synchronous, active-high
//   I_iEnable     in   1   fetch request; held until O_iValid
//   I_iAddress    in   16  fetch byte address; bits [1:0] ignored
//   O_iData       out  32  fetched word; meaningful when O_iValid
//   O_iValid      out  1   1-cycle pulse: fetch complete
//   O_iStall      out  1   I_iEnable & ~O_iValid (combinational)
//   I_dE          in   1   data request; held until O_dDone
//   I_dWe         in   4   byte write enables; 0 = read
//   I_dAddress    in   16  data byte address; bits [1:0] ignored
//   I_dWData      in   32  store data
//   O_dData       out  32  load word; meaningful when O_dDone after a read
//   O_dDone       out  1   1-cycle pulse: data access complete
//   O_dBusy       out  1   I_dE & ~O_dDone (combinational)
//   O_memE        out  1   memory enable, registered
//   O_memWe       out  4   memory byte write enables, registered
//   O_memAddress  out  16  memory byte address, {addr[15:2],2'b00}, registered
//   O_memWData    out  32  memory write data, registered
//   I_memData     in   32  memory read data, valid READ_LATENCY cycles after the O_memE cycle
// BEHAVIOUR
//   Reset: state IDLE, streak=0.
//     O_memE, O_memWe, O_iValid, O_dDone = 0.
//     O_iData, O_dData, O_memAddress, O_memWData = 0.
//   FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE, arbitration at the clock edge:
//     if I_dE & ~(I_iEnable & streak==MAX_DATA_STREAK), grant data;
//     else if I_iEnable, grant fetch;
//     else stay in IDLE.
//     The granted request's address, enables and data are registered to O_mem*; go to ISSUE.
//   ISSUE: O_memE=1 for exactly one cycle.
//     Data write: O_dDone=1 in the next cycle, return to IDLE (no WAIT).
//     Read: go to WAIT.
//   WAIT: counter runs READ_LATENCY-1 cycles (0 cycles when READ_LATENCY=1).
//     Capture I_memData into O_iData or O_dData at the edge READ_LATENCY cycles after ISSUE.
//   RESP: the owner's O_iValid or O_dDone = 1 for one cycle. Back to IDLE.
//     A request still asserted is re-arbitrated in that IDLE cycle.
//   Latency: request seen in IDLE cycle T gives ISSUE at T+1.
//     Read valid at T+READ_LATENCY+2.
//     Write done at T+2.
//   Streak counter (4 bit, saturating):
//     +1 on each data grant while I_iEnable=1.
//     Cleared on a fetch grant, or any IDLE cycle with I_iEnable=0.
//   O_memE=0 in every state except ISSUE. O_memWe=0 for reads and outside ISSUE.
//   Simultaneous I_dE and I_iEnable with streak<MAX: data wins; fetch stays stalled.
//   Requester drops its request mid-transaction: the access still completes.
//     The done/valid pulse is still generated and the data is ignored.
//     No early abort.
//   Data outputs hold their last captured value until the next capture.
//   Reset mid-transaction: state returns to IDLE at the reset edge.
//     O_memE drops, and no valid/done pulse is issued for the aborted access.
//   Only one access is in flight at a time; no pipelining of requests.
// TESTING
//   1. Fetch only, READ_LATENCY=1, I_iAddress=16'h0010, mem word 0xDEADBEEF:
//      -> O_memE at T+1 with O_memAddress=16'h0010; O_iValid and O_iData=0xDEADBEEF at T+3.
//   2. Store I_dWe=4'b1111, addr 16'h0104, data 0x12345678, same cycle as a fetch:
//      -> data issues first with O_memWe=4'hF; O_dDone at T+2; fetch ISSUE at T+3.
//   3. I_dE held continuously with I_iEnable=1, MAX_DATA_STREAK=4:
//      -> exactly 4 data grants, then one fetch grant, then data again.
//   4. READ_LATENCY=3 load from addr 16'h0203:
//      -> O_memAddress=16'h0200; O_dDone at T+5; O_dBusy high from T through T+4.
//   5. I_rst during WAIT of a read:
//      -> next cycle all outputs at reset values, no O_dDone; a later fetch completes normally.

Source files
------------

// File: rtl/ceespu_mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the ceespu fetch and data ports.
// Data has priority, bounded by a streak limit so a pending fetch is always served eventually.
module ceespu_mem_arbiter #(
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_iEnable,
  input  logic [15:0] I_iAddress,
  output logic [31:0] O_iData,
  output logic        O_iValid,
  output logic        O_iStall,
  input  logic        I_dE,
  input  logic [3:0]  I_dWe,
  input  logic [15:0] I_dAddress,
  input  logic [31:0] I_dWData,
  output logic [31:0] O_dData,
  output logic        O_dDone,
  output logic        O_dBusy,
  output logic        O_memE,
  output logic [3:0]  O_memWe,
  output logic [15:0] O_memAddress,
  output logic [31:0] O_memWData,
  input  logic [31:0] I_memData
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  localparam logic [2:0] WAIT_CYCLES = 3'(READ_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX  = 4'(MAX_DATA_STREAK);
  localparam logic [3:0] STREAK_SAT  = 4'hF;

  state_e      state_q,     state_d;
  owner_e      owner_q,     owner_d;
  logic        write_q,     write_d;
  logic [2:0]  wait_cnt_q,  wait_cnt_d;
  logic [3:0]  streak_q,    streak_d;
  logic        mem_e_q,     mem_e_d;
  logic [3:0]  mem_we_q,    mem_we_d;
  logic [15:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] i_data_q,    i_data_d;
  logic        i_valid_q,   i_valid_d;
  logic [31:0] d_data_q,    d_data_d;
  logic        d_done_q,    d_done_d;

  logic data_wins;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{I_iAddress[1:0], I_dAddress[1:0]};

  // Data loses only when a fetch is waiting and the data streak has hit its limit.
  assign data_wins = I_dE & ~(I_iEnable & (streak_q == STREAK_MAX));

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    wait_cnt_d  = wait_cnt_q;
    streak_d    = streak_q;
    mem_e_d     = 1'b0;
    mem_we_d    = 4'h0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_data_d    = i_data_q;
    i_valid_d   = 1'b0;
    d_data_d    = d_data_q;
    d_done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!I_iEnable) begin
          streak_d = '0;
        end
        if (data_wins) begin
          state_d     = ST_ISSUE;
          owner_d     = OWN_DATA;
          write_d     = |I_dWe;
          mem_e_d     = 1'b1;
          mem_we_d    = I_dWe;
          mem_addr_d  = {I_dAddress[15:2], 2'b00};
          mem_wdata_d = I_dWData;
          if (I_iEnable && (streak_q != STREAK_SAT)) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (I_iEnable) begin
          state_d    = ST_ISSUE;
          owner_d    = OWN_FETCH;
          write_d    = 1'b0;
          mem_e_d    = 1'b1;
          mem_addr_d = {I_iAddress[15:2], 2'b00};
          streak_d   = '0;
        end
      end

      ST_ISSUE: begin
        if (write_q) begin
          d_done_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (WAIT_CYCLES == 3'd0) begin
          state_d = ST_RESP;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_CYCLES;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == 3'd1) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end

      ST_RESP: begin
        // Read data is on I_memData during this cycle; the pulse shows up in the next IDLE cycle.
        if (owner_q == OWN_FETCH) begin
          i_data_d  = I_memData;
          i_valid_d = 1'b1;
        end else begin
          d_data_d = I_memData;
          d_done_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      write_q     <= 1'b0;
      wait_cnt_q  <= '0;
      streak_q    <= '0;
      mem_e_q     <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_data_q    <= '0;
      i_valid_q   <= 1'b0;
      d_data_q    <= '0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      wait_cnt_q  <= wait_cnt_d;
      streak_q    <= streak_d;
      mem_e_q     <= mem_e_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_data_q    <= i_data_d;
      i_valid_q   <= i_valid_d;
      d_data_q    <= d_data_d;
      d_done_q    <= d_done_d;
    end
  end

  assign O_iData      = i_data_q;
  assign O_iValid     = i_valid_q;
  assign O_iStall     = I_iEnable & ~i_valid_q;
  assign O_dData      = d_data_q;
  assign O_dDone      = d_done_q;
  assign O_dBusy      = I_dE & ~d_done_q;
  assign O_memE       = mem_e_q;
  assign O_memWe      = mem_we_q;
  assign O_memAddress = mem_addr_q;
  assign O_memWData   = mem_wdata_q;

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Bench for ceespu_mem_arbiter: two instances (READ_LATENCY 1 and 3) share stimulus; a timeline
// model predicts every output each cycle, and directed literal checks pin the model.
module tb_ceespu_mem_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [15:0] i_addr;
  logic        d_e;
  logic [3:0]  d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;

  logic [31:0] o_idata    [2];
  logic        o_ivalid   [2];
  logic        o_istall   [2];
  logic [31:0] o_ddata    [2];
  logic        o_ddone    [2];
  logic        o_dbusy    [2];
  logic        o_meme     [2];
  logic [3:0]  o_memwe    [2];
  logic [15:0] o_memaddr  [2];
  logic [31:0] o_memwdata [2];
  logic [31:0] mem_rdata  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ceespu_mem_arbiter #(.READ_LATENCY(1), .MAX_DATA_STREAK(MAX_STREAK)) dut_rl1 (
    .I_clk(clk), .I_rst(rst),
    .I_iEnable(i_en), .I_iAddress(i_addr),
    .O_iData(o_idata[0]), .O_iValid(o_ivalid[0]), .O_iStall(o_istall[0]),
    .I_dE(d_e), .I_dWe(d_we), .I_dAddress(d_addr), .I_dWData(d_wdata),
    .O_dData(o_ddata[0]), .O_dDone(o_ddone[0]), .O_dBusy(o_dbusy[0]),
    .O_memE(o_meme[0]), .O_memWe(o_memwe[0]), .O_memAddress(o_memaddr[0]),
    .O_memWData(o_memwdata[0]), .I_memData(mem_rdata[0])
  );

  ceespu_mem_arbiter #(.READ_LATENCY(3), .MAX_DATA_STREAK(MAX_STREAK)) dut_rl3 (
    .I_clk(clk), .I_rst(rst),
    .I_iEnable(i_en), .I_iAddress(i_addr),
    .O_iData(o_idata[1]), .O_iValid(o_ivalid[1]), .O_iStall(o_istall[1]),
    .I_dE(d_e), .I_dWe(d_we), .I_dAddress(d_addr), .I_dWData(d_wdata),
    .O_dData(o_ddata[1]), .O_dDone(o_ddone[1]), .O_dBusy(o_dbusy[1]),
    .O_memE(o_meme[1]), .O_memWe(o_memwe[1]), .O_memAddress(o_memaddr[1]),
    .O_memWData(o_memwdata[1]), .I_memData(mem_rdata[1])
  );

  function automatic int rl_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4)   return 32'hDEADBEEF;
    if (idx == 128) return 32'hCAFEF00D;
    return 32'h1000_0000 + 32'(idx);
  endfunction

  // ---------------- memory macro model (environment) ----------------
  logic [31:0] env_mem [2][256];
  logic [31:0] rd_pipe [2][8];

  always_comb begin
    mem_rdata[0] = rd_pipe[0][0];
    mem_rdata[1] = rd_pipe[1][2];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 7; s > 0; s--) rd_pipe[k][s] <= rd_pipe[k][s-1];
      if (o_meme[k] && o_memwe[k] == 4'h0)
        rd_pipe[k][0] <= env_mem[k][o_memaddr[k][9:2]];
      else
        rd_pipe[k][0] <= 32'hBAD0_0000 | 32'(k);
      if (o_meme[k])
        for (int b = 0; b < 4; b++)
          if (o_memwe[k][b]) env_mem[k][o_memaddr[k][9:2]][8*b +: 8] <= o_memwdata[k][8*b +: 8];
    end
  end

  // ---------------- reference model: transaction timeline ----------------
  logic        exp_meme   [2];
  logic [3:0]  exp_we     [2];
  logic [15:0] exp_addr   [2];
  logic [31:0] exp_wdata  [2];
  logic [31:0] exp_idata  [2];
  logic [31:0] exp_ddata  [2];
  logic        exp_ivalid [2];
  logic        exp_ddone  [2];
  int          next_idle  [2];
  int          streak     [2];
  int          t_end      [2];
  bit          t_fetch    [2];
  bit          t_write    [2];
  logic [31:0] t_rdata    [2];
  logic [31:0] ref_mem    [2][256];
  int          cyc = 0;
  bit          started = 1'b0;

  task automatic model_step(input int k);
    int c;
    c = cyc;
    if (rst) begin
      exp_meme[k] = 0; exp_we[k] = 0; exp_addr[k] = 0; exp_wdata[k] = 0;
      exp_idata[k] = 0; exp_ddata[k] = 0; exp_ivalid[k] = 0; exp_ddone[k] = 0;
      next_idle[k] = c + 1; streak[k] = 0; t_end[k] = -1;
      return;
    end
    exp_meme[k] = 0; exp_we[k] = 0; exp_ivalid[k] = 0; exp_ddone[k] = 0;
    if (t_end[k] == c + 1) begin
      if (t_fetch[k]) begin
        exp_ivalid[k] = 1; exp_idata[k] = t_rdata[k];
      end else begin
        exp_ddone[k] = 1;
        if (!t_write[k]) exp_ddata[k] = t_rdata[k];
      end
      t_end[k] = -1;
    end
    if (c >= next_idle[k]) begin
      if (d_e && !(i_en && streak[k] == MAX_STREAK)) begin
        exp_meme[k] = 1; exp_we[k] = d_we; exp_addr[k] = {d_addr[15:2], 2'b00};
        exp_wdata[k] = d_wdata; t_fetch[k] = 0; t_write[k] = (d_we != 0);
        if (t_write[k]) begin
          for (int b = 0; b < 4; b++)
            if (d_we[b]) ref_mem[k][d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
          t_end[k] = c + 2;
        end else begin
          t_rdata[k] = ref_mem[k][d_addr[9:2]];
          t_end[k] = c + rl_of(k) + 2;
        end
        streak[k] = i_en ? ((streak[k] == 15) ? 15 : streak[k] + 1) : 0;
        next_idle[k] = t_end[k];
      end else if (i_en) begin
        exp_meme[k] = 1; exp_addr[k] = {i_addr[15:2], 2'b00};
        t_fetch[k] = 1; t_write[k] = 0; t_rdata[k] = ref_mem[k][i_addr[9:2]];
        t_end[k] = c + rl_of(k) + 2; next_idle[k] = t_end[k]; streak[k] = 0;
      end else begin
        streak[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) started = 1'b1;
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        p = $sformatf("rl%0d_", rl_of(k));
        check({p, "memE"},   32'(o_meme[k]),   32'(exp_meme[k]));
        check({p, "memWe"},  32'(o_memwe[k]),  32'(exp_we[k]));
        if (exp_meme[k]) check({p, "memAddr"}, 32'(o_memaddr[k]), 32'(exp_addr[k]));
        if (exp_meme[k] && exp_we[k] != 0) check({p, "memWData"}, o_memwdata[k], exp_wdata[k]);
        check({p, "iValid"}, 32'(o_ivalid[k]), 32'(exp_ivalid[k]));
        check({p, "dDone"},  32'(o_ddone[k]),  32'(exp_ddone[k]));
        check({p, "iData"},  o_idata[k], exp_idata[k]);
        check({p, "dData"},  o_ddata[k], exp_ddata[k]);
        check({p, "iStall"}, 32'(o_istall[k]), 32'(i_en & ~exp_ivalid[k]));
        check({p, "dBusy"},  32'(o_dbusy[k]),  32'(d_e & ~exp_ddone[k]));
      end
    end
  end

  // grant order of the RL=1 instance, 1 = data, 0 = fetch
  bit glog[$];
  bit log_en = 1'b0;
  always @(negedge clk) if (log_en && o_meme[0] === 1'b1) glog.push_back(o_memwe[0] != 4'h0);

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; i_en = 1'b0; d_e = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic new_cycle();
    @(negedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) begin
        env_mem[k][i] <= init_word(i);
        ref_mem[k][i] = init_word(i);
      end
    rst = 1'b1; i_en = 1'b0; i_addr = '0; d_e = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
    do_reset();

    // 1: lone fetch of 0x0010
    new_cycle();
    i_en = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    check("t1_memE", 32'(o_meme[0]), 1);
    check("t1_memAddr", 32'(o_memaddr[0]), 32'h0010);
    check("t1_iStall", 32'(o_istall[0]), 1);
    repeat (2) @(negedge clk);
    check("t1_iValid", 32'(o_ivalid[0]), 1);
    check("t1_iData", o_idata[0], 32'hDEADBEEF);
    check("t1_iStall_low", 32'(o_istall[0]), 0);
    #1 i_en = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_rl3_iValid", 32'(o_ivalid[1]), 1);
    check("t1_rl3_iData", o_idata[1], 32'hDEADBEEF);
    repeat (3) @(negedge clk);

    // 2: store and fetch in the same cycle, store wins
    new_cycle();
    i_en = 1'b1; i_addr = 16'h0020;
    d_e = 1'b1; d_we = 4'hF; d_addr = 16'h0104; d_wdata = 32'h12345678;
    @(negedge clk);
    check("t2_memE", 32'(o_meme[0]), 1);
    check("t2_memWe", 32'(o_memwe[0]), 32'hF);
    check("t2_memAddr", 32'(o_memaddr[0]), 32'h0104);
    check("t2_memWData", o_memwdata[0], 32'h12345678);
    check("t2_iStall", 32'(o_istall[0]), 1);
    @(negedge clk);
    check("t2_dDone", 32'(o_ddone[0]), 1);
    check("t2_rl3_dDone", 32'(o_ddone[1]), 1);
    #1 d_e = 1'b0;
    @(negedge clk);
    check("t2_fetch_memE", 32'(o_meme[0]), 1);
    check("t2_fetch_addr", 32'(o_memaddr[0]), 32'h0020);
    check("t2_fetch_we", 32'(o_memwe[0]), 0);
    repeat (2) @(negedge clk);
    check("t2_iValid", 32'(o_ivalid[0]), 1);
    check("t2_iData", o_idata[0], 32'h1000_0008);
    #1 i_en = 1'b0;
    repeat (5) @(negedge clk);

    // 3: continuous stores against a pending fetch
    do_reset();
    glog.delete();
    log_en = 1'b1;
    i_en = 1'b1; i_addr = 16'h0030;
    d_e = 1'b1; d_we = 4'hF; d_addr = 16'h0040; d_wdata = 32'h0BADF00D;
    for (int n = 0; n < 60 && glog.size() < 6; n++) @(negedge clk);
    check("t3_grant_count", (glog.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    if (glog.size() >= 6) begin
      check("t3_grant0", 32'(glog[0]), 1);
      check("t3_grant1", 32'(glog[1]), 1);
      check("t3_grant2", 32'(glog[2]), 1);
      check("t3_grant3", 32'(glog[3]), 1);
      check("t3_grant4_fetch", 32'(glog[4]), 0);
      check("t3_grant5", 32'(glog[5]), 1);
    end
    #1 i_en = 1'b0; d_e = 1'b0;
    log_en = 1'b0;
    repeat (8) @(negedge clk);

    // 4: RL=3 load from an unaligned address
    do_reset();
    d_e = 1'b1; d_we = 4'h0; d_addr = 16'h0203;
    #1 check("t4_dBusy_T", 32'(o_dbusy[1]), 1);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check($sformatf("t4_dBusy_T%0d", j), 32'(o_dbusy[1]), 1);
      if (j == 1) begin
        check("t4_memE", 32'(o_meme[1]), 1);
        check("t4_memAddr", 32'(o_memaddr[1]), 32'h0200);
        check("t4_memWe", 32'(o_memwe[1]), 0);
      end
    end
    @(negedge clk);
    check("t4_dDone", 32'(o_ddone[1]), 1);
    check("t4_dData", o_ddata[1], 32'hCAFEF00D);
    check("t4_dBusy_low", 32'(o_dbusy[1]), 0);
    #1 d_e = 1'b0;
    repeat (6) @(negedge clk);

    // byte-masked store then read back
    new_cycle();
    d_e = 1'b1; d_we = 4'b0011; d_addr = 16'h0106; d_wdata = 32'hAABBCCDD;
    repeat (2) @(negedge clk);
    check("t4b_store_done", 32'(o_ddone[1]), 1);
    #1 d_we = 4'h0; d_addr = 16'h0104;
    repeat (5) @(negedge clk);
    check("t4b_load_done", 32'(o_ddone[1]), 1);
    check("t4b_load_data", o_ddata[1], 32'h1234CCDD);
    #1 d_e = 1'b0;
    repeat (8) @(negedge clk);

    // 5: reset while the RL=3 read sits in WAIT
    new_cycle();
    d_e = 1'b1; d_we = 4'h0; d_addr = 16'h0200;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1; d_e = 1'b0;
    @(negedge clk);
    check("t5_memE", 32'(o_meme[1]), 0);
    check("t5_memWe", 32'(o_memwe[1]), 0);
    check("t5_memAddr", 32'(o_memaddr[1]), 0);
    check("t5_memWData", o_memwdata[1], 0);
    check("t5_iValid", 32'(o_ivalid[1]), 0);
    check("t5_dDone", 32'(o_ddone[1]), 0);
    check("t5_iData", o_idata[1], 0);
    check("t5_dData", o_ddata[1], 0);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    #1 i_en = 1'b1; i_addr = 16'h0010;
    begin
      int n;
      n = 0;
      while (o_ivalid[1] !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_fetch_valid", 32'(o_ivalid[1]), 1);
    check("t5_fetch_data", o_idata[1], 32'hDEADBEEF);
    #1 i_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
